// File: rtl/wait_state_memory.sv
// Word-addressed memory with a programmable wait-state latency and a four-phase
// ready handshake. One access is served at a time: IDLE accepts, BUSY counts
// down the wait states, and ACK holds ready until the requester drops its request.
module wait_state_memory #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 readM,
    input  logic                 writeM,
    input  logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic                 ready,
    output logic                 bus_err
);

    localparam int unsigned Depth   = 1 << ADDR_BITS;
    localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("wait_state_memory: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [WORD_SIZE-1:0] rdata_q, rdata_d;
    logic                 is_write_q, is_write_d;
    logic                 oor_q, oor_d;
    logic                 err_q, err_d;
    logic                 req;
    logic                 addr_oor;
    logic                 commit;
    logic                 drive_rd;

    // Storage is deliberately outside the reset domain.
    logic [WORD_SIZE-1:0] mem [Depth];

    assign req      = readM | writeM;
    assign addr_oor = (address >> ADDR_BITS) != '0;

    // Next-state logic: accept, count wait states, commit, then hold ACK.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        is_write_d = is_write_q;
        oor_d      = oor_q;
        err_d      = err_q;
        commit     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d    = StBusy;
                    cnt_d      = CntLoad;
                    addr_d     = address[ADDR_BITS-1:0];
                    // A read/write conflict is served as a read.
                    is_write_d = writeM & ~readM;
                    oor_d      = addr_oor;
                    if (writeM) begin
                        wdata_d = data;
                    end
                    if ((readM & writeM) | addr_oor) begin
                        err_d = 1'b1;
                    end
                end
            end
            StBusy: begin
                if (!req) begin
                    // Requester gave up: no write, no ready.
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = StAck;
                    commit  = is_write_q & ~oor_q;
                    rdata_d = oor_q ? '0 : mem[addr_q];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck: begin
                if (!req) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control and latched-request registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            is_write_q <= 1'b0;
            oor_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            is_write_q <= is_write_d;
            oor_q      <= oor_d;
            err_q      <= err_d;
        end
    end

    // Array write; gated by reset_n so an edge inside reset cannot commit.
    always_ff @(posedge clk) begin
        if (commit && reset_n) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign ready   = (state_q == StAck);
    assign bus_err = err_q;

    // readM gates the driver directly so the bus frees as soon as it falls.
    assign drive_rd = (state_q == StAck) & ~is_write_q & readM;
    assign data     = drive_rd ? rdata_q : {WORD_SIZE{1'bz}};

endmodule
